multi_channel_clock_divider: RTL
================================

Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the single fixed divider.
- Provides NUM_CH independent divided-clock channels from one clock. Each channel has:
  - a runtime-programmable divisor with glitch-free shadow update;
  - a per-channel enable;
  - a per-channel mode: 50% duty toggle clock, or one-cycle pulse.
- Drives the board-level slow clocks and timebase strobes, for example 1 Hz display and debounce ticks from 50 MHz.

Parameters:
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 25: counter and divisor width in bits.
- RESET_DIV, 25000000: divisor loaded into every channel at reset. Must fit in CNT_W bits.
- SEL_W, 2: cfg_sel width; the integrator sets it to max(1, clog2(NUM_CH)).

Ports:
- clk_in, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- ch_en, input, NUM_CH: per-channel run enable.
- mode, input, NUM_CH: per-channel mode. 0 = toggle (50% duty), 1 = pulse.
- cfg_we, input, 1: divisor write strobe, one cycle per write.
- cfg_sel, input, SEL_W: channel index for the write.
- cfg_div, input, CNT_W: new divisor value D.
- cfg_pending, output, NUM_CH: shadow written but not yet active.
- clk_out, output, NUM_CH: divided clock (toggle mode) or pulse (pulse mode).
- tick, output, NUM_CH: one-cycle strobe at every terminal count, in both modes.

Behaviour:
- Reset (rst_n low, asynchronous) sets every channel to:
  - cnt = 0, clk_out = 0, tick = 0, cfg_pending = 0;
  - active divisor = shadow divisor = RESET_DIV.
- All outputs are registered. There is no combinational path from inputs to outputs.

Per-channel state: cnt, act_div, sh_div, pend.

Running (ch_en = 1 and act_div ≠ 0), evaluated at each clk_in edge:
- Terminal count is cnt ≥ act_div − 1. Using ≥ rather than == guards against out-of-range values.
- On terminal count:
  - cnt ← 0;
  - tick ← 1;
  - toggle mode: clk_out ← ~clk_out;
  - pulse mode: clk_out ← 1;
  - if pend: act_div ← sh_div and pend ← 0.
- Otherwise:
  - cnt ← cnt + 1;
  - tick ← 0;
  - pulse mode: clk_out ← 0; toggle mode: clk_out holds.
- Resulting periods:
  - toggle: period 2·D cycles, exact 50% duty;
  - pulse: clk_out and tick high for 1 cycle every D cycles.
- D = 1: toggle gives clk_in/2; pulse gives tick high continuously.
- First tick after enable: rises at the D-th edge, counting the first edge with ch_en sampled high as edge 1.

Idle (ch_en = 0, or act_div = 0):
- cnt ← 0, clk_out ← 0, tick ← 0.
- If pend: act_div ← sh_div and pend ← 0 at the next edge.
- Re-enabling restarts the channel from phase 0.

Configuration writes:
- A write with cfg_we = 1 and cfg_sel < NUM_CH does sh_div[cfg_sel] ← cfg_div and pend ← 1.
- A write with cfg_sel ≥ NUM_CH is ignored.
- A divisor change never truncates or stretches the current half-period. It takes effect only at a terminal count, or while the channel is idle.
- Write in the same cycle as a terminal count on that channel:
  - the new value is captured in the shadow and pend stays 1 (the write wins);
  - the new value applies at the following terminal count.
- Back-to-back writes to the same channel: the last value wins.

Mode change while running:
- cnt is unaffected.
- Toggle → pulse: clk_out is driven per pulse rules from the next edge.
- Pulse → toggle: clk_out holds its current level until the next terminal count.

Other rules:
- Channels are fully independent. Writes to one channel never disturb another.
- Asynchronous reset mid-operation returns all state to reset values immediately. Any pending shadow value is discarded.

Test Plan:
Bench parameters for all scenarios: NUM_CH=2, CNT_W=8, SEL_W=1, RESET_DIV=4.
1. Release reset; ch_en=2'b11, mode=2'b00 -> both clk_out toggle every 4 cycles (period 8, 50%); tick high 1 cycle every 4; first tick at edge 4.
2. ch0 mode=1 -> clk_out[0] == tick[0], high 1 of every 4 cycles. ch1 stays toggle, phase unaffected.
3. Mid-period write cfg_sel=0, cfg_div=6 -> cfg_pending[0]=1; the current half-period still ends at 4; the next half-periods are 6; cfg_pending[0] clears at that terminal edge.
4. Write coincident with the ch0 terminal count, and a write with cfg_div=0 -> first: the value applies one terminal later. Second: once applied, the channel idles with clk_out=0, tick=0; rewriting 3 recovers with the first tick 3 edges later.
5. ch_en[1]=0 while cfg_div=2 is written to ch1 -> pending applied at the next edge; re-enable gives period 4 starting from phase 0.
6. Assert rst_n low mid-count with a pending write -> outputs 0 immediately; after release the divisor is 4 and cfg_pending=0.

Source files
------------

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock divider.
// Each channel divides clk_in by a runtime divisor and produces either a
// 50% duty clock (toggle mode) or a one-cycle pulse (pulse mode), plus a
// terminal-count tick. Divisor writes land in a shadow register and are
// promoted to the active divisor only at a terminal count or while the
// channel is idle, so a running half-period is never cut short or stretched.
module multi_channel_clock_divider #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 25,
    parameter int RESET_DIV = 25000000,
    parameter int SEL_W     = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] RESET_DIV_V = CNT_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] act_div_q, act_div_d;
    logic [NUM_CH-1:0][CNT_W-1:0] sh_div_q, sh_div_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic [NUM_CH-1:0]            clk_out_q, clk_out_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;

    logic [NUM_CH-1:0]            wr_hit;
    logic [NUM_CH-1:0]            running;
    logic [NUM_CH-1:0]            terminal;

    // Decode the configuration write; selects beyond NUM_CH match no channel.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = cfg_we && (32'(cfg_sel) == i);
        end
    end

    // Per-channel run status and terminal-count detection (>= tolerates a
    // counter left above a freshly shortened divisor).
    always_comb begin
        running  = '0;
        terminal = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            running[i]  = ch_en[i] && (act_div_q[i] != '0);
            terminal[i] = cnt_q[i] >= (act_div_q[i] - ONE);
        end
    end

    // Next-state for counters, outputs and the shadow/active divisor pair.
    always_comb begin
        cnt_d     = cnt_q;
        act_div_d = act_div_q;
        sh_div_d  = sh_div_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = tick_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (running[i]) begin
                if (terminal[i]) begin
                    cnt_d[i]     = '0;
                    tick_d[i]    = 1'b1;
                    clk_out_d[i] = mode[i] ? 1'b1 : ~clk_out_q[i];
                    if (pend_q[i]) begin
                        act_div_d[i] = sh_div_q[i];
                        pend_d[i]    = 1'b0;
                    end
                end else begin
                    cnt_d[i]  = cnt_q[i] + ONE;
                    tick_d[i] = 1'b0;
                    if (mode[i]) begin
                        clk_out_d[i] = 1'b0;
                    end
                end
            end else begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
                if (pend_q[i]) begin
                    act_div_d[i] = sh_div_q[i];
                    pend_d[i]    = 1'b0;
                end
            end
            // A write in the same cycle as a promotion wins: the new value
            // stays pending for the following terminal count.
            if (wr_hit[i]) begin
                sh_div_d[i] = cfg_div;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // State registers; reset discards any pending shadow value.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            act_div_q <= {NUM_CH{RESET_DIV_V}};
            sh_div_q  <= {NUM_CH{RESET_DIV_V}};
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            act_div_q <= act_div_d;
            sh_div_q  <= sh_div_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg_pending = pend_q;
    assign clk_out     = clk_out_q;
    assign tick        = tick_q;

endmodule
